banner_overlay: RTL and testbench
=================================

# banner_overlay

Parametrised full-screen bitmap banner for the VGA path. It renders one of several stored cell-grid messages (start, won, lost, pause) as a 1-bit `flag` for the colour mux. Each frame it can optionally blink and horizontally scroll the message. It sits between the pixel counters and the colour mux, and replaces the per-message fixed overlay modules.

## Interface
Parameters:
- `CELL_SHIFT`, 4: log2 of cell size in pixels (16×16 cells).
- `COLS`, 30: cells per row.
- `ROWS`, 30: cell rows.
- `X_OFF`, 5: left margin of the grid, in cells.
- `NUM_MSG`, 4: number of stored messages.
- `BLINK_FRAMES`, 30: frames per blink half-period (≥1).
- `SCROLL_FRAMES`, 4: frames per one-cell scroll step (≥1).

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: synchronous, active-high reset.
- `pixel_x` in 10: current pixel column.
- `pixel_y` in 10: current pixel row.
- `frame_tick` in 1: one-cycle pulse per frame, asserted during vertical blanking.
- `msg_sel` in $clog2(NUM_MSG): requested message.
- `show` in 1: banner enable.
- `blink_en` in 1: enable blinking.
- `scroll_en` in 1: enable horizontal scroll.
- `flag` out 1: registered pixel-on.
- `cur_msg` out $clog2(NUM_MSG): message currently displayed.

## Operation
- Cell coordinates:
  - `cx = pixel_x >> CELL_SHIFT`, `cy = pixel_y >> CELL_SHIFT`.
  - Grid column `gx = cx − X_OFF`.
  - If `cx < X_OFF`, `gx ≥ COLS` or `cy ≥ ROWS`, the pixel is outside the grid and `flag` = 0. There is no modular wrap of the subtraction.
- Scrolled column: `sx = (gx + scroll_off) mod COLS`. Bit `sx` of row `cy` is read from the ROM. Column 0 is the leftmost column, i.e. the MSB of the row word.
- Output: `flag = show & vis_phase & rom_bit & in_grid`.
- Frame-synchronous state, updated only on `frame_tick`:
  - `cur_msg` ← `msg_sel`. If the value changes, `scroll_off` ← 0, `scroll_cnt` ← 0, `blink_cnt` ← 0, `vis_phase` ← 1.
  - Blink:
    - If `blink_en`: `blink_cnt` increments. On reaching `BLINK_FRAMES−1` it wraps to 0 and `vis_phase` toggles.
    - If `blink_en` = 0: `blink_cnt` ← 0 and `vis_phase` ← 1.
  - Scroll:
    - If `scroll_en`: `scroll_cnt` increments. On reaching `SCROLL_FRAMES−1` it wraps to 0 and `scroll_off` ← (`scroll_off`+1) mod `COLS`.
    - If `scroll_en` = 0: `scroll_off` and `scroll_cnt` hold. Scroll pauses and does not reset.
  - A message change takes priority over blink and scroll updates in the same tick.
- `msg_sel` values ≥ `NUM_MSG` are ignored: `cur_msg` holds.
- `show`, `blink_en` and `scroll_en` do not affect the state registers except as stated above. `show` = 0 gates only `flag`.

## Timing
- `flag` has a fixed 1-cycle latency from `pixel_x`/`pixel_y`. The ROM is combinational or LUT, and the address and gate are registered together with the same `vis_phase`/`scroll_off` snapshot.
- Message, blink and scroll changes take effect on the cycle after `frame_tick`, never mid-frame, so there is no tearing.
- Reset values:
  - `flag` = 0, `cur_msg` = 0.
  - `scroll_off` = 0, `scroll_cnt` = 0, `blink_cnt` = 0, `vis_phase` = 1.
- Reset mid-frame: `flag` is 0 on the cycle after `rst`. Rendering resumes with the reset state on the next cycle, without waiting for `frame_tick`.
- `frame_tick` asserted during `rst` is ignored.

## Structure
- Package `frogger_banner_pkg`:
  - Message IDs `MSG_START`=0, `MSG_WON`=1, `MSG_LOST`=2, `MSG_PAUSE`=3.
  - Grid constants.
  - Row-word typedef `logic [0:COLS-1]`.
- Sub-module `banner_rom`: address {msg, row}, returns a COLS-bit row word, initialised from bitmaps that are pure data.
- `banner_overlay` holds the counters, the coordinate arithmetic and the output register.

## Test plan
- Reset and static render:
  - Stimulus: `rst` 2 cycles; `msg_sel`=1, `show`=1, one `frame_tick`.
  - Sweep all pixels.
  - Required: `flag` matches the `MSG_WON` bitmap (e.g. pixel (6·16, 8·16) → 1, pixel (5·16, 8·16) → 0) with 1-cycle latency. Pixels with `cx` < 5 or `cy` ≥ 30 → 0.
- Blink:
  - Stimulus: `blink_en`=1, `BLINK_FRAMES`=30, 60 ticks.
  - Required: `vis_phase` is 1 for ticks 0–29 and 0 for ticks 30–59; while low, `flag` = 0 everywhere. With `blink_en`=0, `vis_phase` = 1 immediately after the next tick.
- Scroll wrap:
  - Stimulus: `scroll_en`=1, `SCROLL_FRAMES`=4, 120 ticks.
  - Required: `scroll_off` steps every 4 ticks and returns to 0 after 30 steps; grid column 29 at offset 1 shows source column 0.
- Message change mid-scroll:
  - Stimulus: `scroll_off`=7, `blink` phase low; `msg_sel` 1→2 on a tick where a scroll step is also due.
  - Required: after the tick `scroll_off`=0, `vis_phase`=1, `cur_msg`=2.
- Mid-frame `msg_sel` change and invalid select:
  - Stimulus: `msg_sel` changed with no `frame_tick`.
  - Required: `flag` still follows the old message until the next tick.
  - Stimulus: `msg_sel`=3 with `NUM_MSG`=3.
  - Required: `cur_msg` unchanged.
- Reset mid-operation:
  - Stimulus: assert `rst` with `scroll_off`=12 and `blink` phase low.
  - Required: the next cycle has `flag`=0, `scroll_off`=0, `vis_phase`=1, `cur_msg`=0.

Source files
------------

// File: rtl/frogger_banner_pkg.sv
// Shared constants, message IDs and the row-word type for the full-screen banner overlay.
package frogger_banner_pkg;

    localparam int unsigned GRID_COLS   = 30;
    localparam int unsigned GRID_ROWS   = 30;
    localparam int unsigned CELL_SHIFT  = 4;
    localparam int unsigned GRID_X_OFF  = 5;
    localparam int unsigned NUM_BITMAPS = 4;

    // Glyph text occupies a 5-row band starting at grid row 8.
    localparam int unsigned TEXT_ROW0 = 8;
    localparam int unsigned TEXT_H    = 5;

    typedef enum logic [1:0] {
        MSG_START = 2'd0,
        MSG_WON   = 2'd1,
        MSG_LOST  = 2'd2,
        MSG_PAUSE = 2'd3
    } msg_id_e;

    // Column 0 (leftmost on screen) is the MSB of the word.
    typedef logic [0:GRID_COLS-1] row_word_t;

endpackage

// File: rtl/banner_rom.sv
// Combinational bitmap store: one row word per {message, row}; rows outside the text band are blank.
module banner_rom
    import frogger_banner_pkg::*;
#(
    parameter int unsigned MSG_W = 2,
    parameter int unsigned ROW_W = 5
) (
    input  logic [MSG_W-1:0] msg,
    input  logic [ROW_W-1:0] row,
    output row_word_t        word
);

    // Indexed by MSG_START, MSG_WON, MSG_LOST, MSG_PAUSE in that order.
    localparam row_word_t GLYPHS [NUM_BITMAPS][TEXT_H] = '{
        '{ 30'b0111_0111_0010_0110_0111_0000_0000_00,
           30'b0100_0010_0101_0101_0010_0000_0000_00,
           30'b0111_0010_0111_0110_0010_0000_0000_00,
           30'b0001_0010_0101_0101_0010_0000_0000_00,
           30'b0111_0010_0101_0101_0010_0000_0000_00 },
        '{ 30'b0101_0111_0110_0000_0000_0000_0000_00,
           30'b0101_0101_0101_0000_0000_0000_0000_00,
           30'b0101_0101_0101_0000_0000_0000_0000_00,
           30'b0111_0101_0101_0000_0000_0000_0000_00,
           30'b0101_0111_0101_0000_0000_0000_0000_00 },
        '{ 30'b0100_0111_0111_0111_0000_0000_0000_00,
           30'b0100_0101_0100_0010_0000_0000_0000_00,
           30'b0100_0101_0111_0010_0000_0000_0000_00,
           30'b0100_0101_0001_0010_0000_0000_0000_00,
           30'b0111_0111_0111_0010_0000_0000_0000_00 },
        '{ 30'b0110_0010_0101_0111_0111_0000_0000_00,
           30'b0101_0101_0101_0100_0100_0000_0000_00,
           30'b0110_0111_0101_0111_0110_0000_0000_00,
           30'b0100_0101_0101_0001_0100_0000_0000_00,
           30'b0100_0101_0111_0111_0111_0000_0000_00 }
    };

    logic [ROW_W-1:0] row_rel;

    // Rows above the band wrap to large values and fail the height test.
    always_comb begin
        word    = '0;
        row_rel = row - ROW_W'(TEXT_ROW0);
        if ((32'(msg) < NUM_BITMAPS) && (row_rel < ROW_W'(TEXT_H))) begin
            word = GLYPHS[2'(msg)][3'(row_rel)];
        end
    end

endmodule

// File: rtl/banner_overlay.sv
// Frame-synchronous banner renderer: blink/scroll/message state updates on frame_tick, registered 1-bit pixel flag.
module banner_overlay
    import frogger_banner_pkg::*;
#(
    parameter int unsigned CELL_SHIFT    = 4,
    parameter int unsigned COLS          = 30,
    parameter int unsigned ROWS          = 30,
    parameter int unsigned X_OFF         = 5,
    parameter int unsigned NUM_MSG       = 4,
    parameter int unsigned BLINK_FRAMES  = 30,
    parameter int unsigned SCROLL_FRAMES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [9:0]                 pixel_x,
    input  logic [9:0]                 pixel_y,
    input  logic                       frame_tick,
    input  logic [$clog2(NUM_MSG)-1:0] msg_sel,
    input  logic                       show,
    input  logic                       blink_en,
    input  logic                       scroll_en,
    output logic                       flag,
    output logic [$clog2(NUM_MSG)-1:0] cur_msg
);

    localparam int unsigned MSG_W    = $clog2(NUM_MSG);
    localparam int unsigned COL_W    = $clog2(COLS);
    localparam int unsigned ROW_W    = $clog2(ROWS);
    localparam int unsigned BLINK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned SCROLL_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    localparam logic [9:0] X_OFF_V = 10'(X_OFF);
    localparam logic [9:0] COLS_V  = 10'(COLS);
    localparam logic [9:0] ROWS_V  = 10'(ROWS);

    logic                flag_q, flag_d;
    logic [MSG_W-1:0]    cur_msg_q, cur_msg_d;
    logic [COL_W-1:0]    scroll_off_q, scroll_off_d;
    logic [SCROLL_W-1:0] scroll_cnt_q, scroll_cnt_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic                vis_phase_q, vis_phase_d;

    logic [9:0]       cx, cy, gx, sx_sum;
    logic [COL_W-1:0] sx;
    logic             in_grid;
    logic             msg_change;
    row_word_t        rom_word;

    banner_rom #(
        .MSG_W (MSG_W),
        .ROW_W (ROW_W)
    ) u_rom (
        .msg  (cur_msg_q),
        .row  (ROW_W'(cy)),
        .word (rom_word)
    );

    // Pixel to grid cell; the left-margin subtraction deliberately has no wrap.
    always_comb begin
        cx      = pixel_x >> CELL_SHIFT;
        cy      = pixel_y >> CELL_SHIFT;
        gx      = cx - X_OFF_V;
        in_grid = (cx >= X_OFF_V) && (gx < COLS_V) && (cy < ROWS_V);
        sx_sum  = gx + 10'(scroll_off_q);
        sx      = (sx_sum >= COLS_V) ? COL_W'(sx_sum - COLS_V) : COL_W'(sx_sum);
        flag_d  = show & vis_phase_q & in_grid & rom_word[sx];
    end

    // Per-frame state; a message change overrides blink and scroll in the same tick.
    always_comb begin
        cur_msg_d    = cur_msg_q;
        scroll_off_d = scroll_off_q;
        scroll_cnt_d = scroll_cnt_q;
        blink_cnt_d  = blink_cnt_q;
        vis_phase_d  = vis_phase_q;
        msg_change   = (32'(msg_sel) < NUM_MSG) && (msg_sel != cur_msg_q);

        if (frame_tick) begin
            if (msg_change) begin
                cur_msg_d    = msg_sel;
                scroll_off_d = '0;
                scroll_cnt_d = '0;
                blink_cnt_d  = '0;
                vis_phase_d  = 1'b1;
            end else begin
                if (blink_en) begin
                    if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
                        blink_cnt_d = '0;
                        vis_phase_d = ~vis_phase_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                    end
                end else begin
                    blink_cnt_d = '0;
                    vis_phase_d = 1'b1;
                end

                if (scroll_en) begin
                    if (scroll_cnt_q == SCROLL_W'(SCROLL_FRAMES - 1)) begin
                        scroll_cnt_d = '0;
                        scroll_off_d = (scroll_off_q == COL_W'(COLS - 1)) ? '0
                                                                          : scroll_off_q + COL_W'(1);
                    end else begin
                        scroll_cnt_d = scroll_cnt_q + SCROLL_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q       <= 1'b0;
            cur_msg_q    <= '0;
            scroll_off_q <= '0;
            scroll_cnt_q <= '0;
            blink_cnt_q  <= '0;
            vis_phase_q  <= 1'b1;
        end else begin
            flag_q       <= flag_d;
            cur_msg_q    <= cur_msg_d;
            scroll_off_q <= scroll_off_d;
            scroll_cnt_q <= scroll_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            vis_phase_q  <= vis_phase_d;
        end
    end

    assign flag    = flag_q;
    assign cur_msg = cur_msg_q;

endmodule

// File: tb/tb_banner_overlay.sv
// Directed bench for banner_overlay: static render sweep, blink, scroll wrap, message change, invalid select, reset.
module tb_banner_overlay;

    logic       clk = 1'b0;
    logic       rst, frame_tick, show, blink_en, scroll_en;
    logic [9:0] pixel_x, pixel_y;
    logic [1:0] msg_sel, cur_msg, msg_sel3, cur_msg3;
    logic       flag, flag3;

    int n_cmp = 0;
    int n_bad = 0;

    logic [29:0] won_rows [5];

    always #5 clk = ~clk;

    banner_overlay dut (
        .clk        (clk),
        .rst        (rst),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .frame_tick (frame_tick),
        .msg_sel    (msg_sel),
        .show       (show),
        .blink_en   (blink_en),
        .scroll_en  (scroll_en),
        .flag       (flag),
        .cur_msg    (cur_msg)
    );

    // Three-message instance so that select value 3 is out of range.
    banner_overlay #(.NUM_MSG(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .frame_tick (frame_tick),
        .msg_sel    (msg_sel3),
        .show       (1'b1),
        .blink_en   (1'b0),
        .scroll_en  (1'b0),
        .flag       (flag3),
        .cur_msg    (cur_msg3)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic set_cell(input int cx, input int cy);
        pixel_x = 10'(cx * 16 + 5);
        pixel_y = 10'(cy * 16 + 9);
    endtask

    task automatic probe(input string tag, input int cx, input int cy, input int exp);
        set_cell(cx, cy);
        step();
        check_eq(tag, int'(flag), exp);
    endtask

    function automatic int won_px(input int cx, input int cy);
        if (cx < 5 || cx >= 35 || cy >= 30 || cy < 8 || cy > 12) return 0;
        return int'(won_rows[cy - 8][29 - (cx - 5)]);
    endfunction

    initial begin
        won_rows[0] = 30'b0101_0111_0110_0000_0000_0000_0000_00;
        won_rows[1] = 30'b0101_0101_0101_0000_0000_0000_0000_00;
        won_rows[2] = 30'b0101_0101_0101_0000_0000_0000_0000_00;
        won_rows[3] = 30'b0111_0101_0101_0000_0000_0000_0000_00;
        won_rows[4] = 30'b0101_0111_0101_0000_0000_0000_0000_00;

        rst = 1'b1; frame_tick = 1'b0; show = 1'b0; blink_en = 1'b0; scroll_en = 1'b0;
        msg_sel = 2'd0; msg_sel3 = 2'd0; pixel_x = '0; pixel_y = '0;
        step();
        step();
        check_eq("rst_flag", int'(flag), 0);
        check_eq("rst_cur_msg", int'(cur_msg), 0);
        check_eq("rst_vis", int'(dut.vis_phase_q), 1);
        check_eq("rst_off", int'(dut.scroll_off_q), 0);

        // Static render of WON
        rst = 1'b0; msg_sel = 2'd1; show = 1'b1;
        tick();
        check_eq("won_cur_msg", int'(cur_msg), 1);
        probe("won_6_8", 6, 8, 1);
        probe("won_5_8", 5, 8, 0);
        for (int cy = 0; cy < 64; cy++) begin
            for (int cx = 0; cx < 64; cx++) begin
                probe($sformatf("sweep_%0d_%0d", cx, cy), cx, cy, won_px(cx, cy));
            end
        end
        show = 1'b0;
        probe("show_off", 6, 8, 0);
        show = 1'b1;

        // Blink: 30 frames visible, 30 hidden
        blink_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            check_eq($sformatf("blink_vis_%0d", i), int'(dut.vis_phase_q), (i < 30) ? 1 : 0);
            if (i % 10 == 5) probe($sformatf("blink_flag_%0d", i), 6, 8, (i < 30) ? 1 : 0);
            tick();
        end
        check_eq("blink_vis_60", int'(dut.vis_phase_q), 1);
        repeat (30) tick();
        check_eq("blink_low", int'(dut.vis_phase_q), 0);
        probe("blink_low_flag_a", 6, 8, 0);
        probe("blink_low_flag_b", 8, 11, 0);
        blink_en = 1'b0;
        tick();
        check_eq("blink_off_vis", int'(dut.vis_phase_q), 1);
        probe("blink_off_flag", 6, 8, 1);

        // Scroll: one column every 4 frames, wrapping after 30 steps
        scroll_en = 1'b1;
        for (int i = 0; i < 120; i++) begin
            check_eq($sformatf("scroll_off_%0d", i), int'(dut.scroll_off_q), (i / 4) % 30);
            if (i == 4) begin
                probe("scr1_g0", 5, 8, 1);
                probe("scr1_g29", 34, 8, 0);
            end
            if (i == 8) begin
                probe("scr2_g29", 34, 8, 1);
                probe("scr2_g28", 33, 8, 0);
                probe("scr2_g0", 5, 8, 0);
            end
            tick();
        end
        check_eq("scroll_wrap", int'(dut.scroll_off_q), 0);

        // Message change on a frame where a scroll step is due and blink is low
        blink_en = 1'b1;
        repeat (28) tick();
        scroll_en = 1'b0;
        tick();
        check_eq("scroll_pause", int'(dut.scroll_off_q), 7);
        scroll_en = 1'b1;
        repeat (3) tick();
        check_eq("pre_chg_off", int'(dut.scroll_off_q), 7);
        check_eq("pre_chg_vis", int'(dut.vis_phase_q), 0);
        check_eq("pre_chg_scnt", int'(dut.scroll_cnt_q), 3);
        msg_sel = 2'd2;
        tick();
        check_eq("chg_off", int'(dut.scroll_off_q), 0);
        check_eq("chg_vis", int'(dut.vis_phase_q), 1);
        check_eq("chg_cur_msg", int'(cur_msg), 2);
        check_eq("chg_scnt", int'(dut.scroll_cnt_q), 0);
        check_eq("chg_bcnt", int'(dut.blink_cnt_q), 0);
        blink_en = 1'b0; scroll_en = 1'b0;
        probe("lost_6_8", 6, 8, 1);

        // msg_sel change with no frame_tick must not reach the screen
        msg_sel = 2'd0;
        probe("midframe_lost", 10, 9, 1);
        check_eq("midframe_cur_msg", int'(cur_msg), 2);
        tick();
        check_eq("after_tick_cur_msg", int'(cur_msg), 0);
        probe("start_10_9", 10, 9, 0);
        probe("start_6_8", 6, 8, 1);

        // Out-of-range select on the three-message instance
        msg_sel3 = 2'd1;
        tick();
        check_eq("sel3_valid", int'(cur_msg3), 1);
        msg_sel3 = 2'd3;
        tick();
        check_eq("sel3_invalid", int'(cur_msg3), 1);
        set_cell(6, 8);
        step();
        check_eq("sel3_flag", int'(flag3), 1);

        // Reset in the middle of a scrolling, blinked-out frame
        msg_sel = 2'd1;
        tick();
        blink_en = 1'b1; scroll_en = 1'b1;
        repeat (48) tick();
        check_eq("pre_rst_off", int'(dut.scroll_off_q), 12);
        check_eq("pre_rst_vis", int'(dut.vis_phase_q), 0);
        set_cell(6, 8);
        rst = 1'b1; frame_tick = 1'b1;
        step();
        check_eq("rst_mid_flag", int'(flag), 0);
        check_eq("rst_mid_off", int'(dut.scroll_off_q), 0);
        check_eq("rst_mid_vis", int'(dut.vis_phase_q), 1);
        check_eq("rst_mid_cur_msg", int'(cur_msg), 0);
        rst = 1'b0; frame_tick = 1'b0; blink_en = 1'b0; scroll_en = 1'b0;
        step();
        check_eq("post_rst_flag", int'(flag), 1);
        check_eq("post_rst_cur_msg", int'(cur_msg), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
